// File: rtl/axis_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_align_pkg
// Description : Shared types and helpers for the AXI-Stream beat-alignment
//               padder. Provides the two-state FSM encoding and a clog2
//               helper that never returns zero, so counters keep at least one
//               bit even when the alignment granule is a single beat.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_align_pkg;

    // PASS forwards upstream beats; PAD inserts filler beats after a short tlast.
    typedef enum logic {
        PASS = 1'b0,
        PAD  = 1'b1
    } align_state_t;

    // Counter width helper: $clog2 with a floor of one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = (n <= 1) ? 1 : $clog2(n);
        return w;
    endfunction

endpackage : axis_align_pkg
`default_nettype wire

// File: rtl/axis_beat_align_pad.sv
`default_nettype none
// ============================================================================
// Module      : axis_beat_align_pad
// Description : Pads every AXI-Stream packet to a whole multiple of RATIO
//               beats so that a downstream RATIO:1 upsizer never emits a
//               partial last word. Real beats pass through unchanged; after a
//               short tlast, PAD_VALUE beats are inserted and tlast moves to
//               the final pad beat. Output is a single register slice
//               (1-cycle latency, 1 beat/cycle under continuous ready).
//
// Parameters  : DSIZE     - beat data width (bits)
//               RATIO     - alignment granule in beats (>= 1)
//               PAD_VALUE - data driven on inserted pad beats
//
// Ports       : clock       in   single clock, rising edge
//               rst_n       in   asynchronous active-low reset
//               in_tdata    in   slave beat data
//               in_tvalid   in   slave valid
//               in_tready   out  slave ready (independent of in_tvalid)
//               in_tlast    in   slave end of packet
//               out_tdata   out  master beat data (registered)
//               out_tvalid  out  master valid (registered)
//               out_tready  in   master ready
//               out_tlast   out  master end of packet, at beat index RATIO-1
//               pad_active  out  high while the FSM is in PAD
//               out_tuser   out  (BEAT_ALIGN_KEEP_EN only) 1 on pad beats
//
// Build macro : BEAT_ALIGN_KEEP_EN - adds out_tuser marking inserted beats.
//
// Revision    : 1.0 - initial release
// ============================================================================
module axis_beat_align_pad
    import axis_align_pkg::*;
#(
    parameter int                 DSIZE     = 8,
    parameter int                 RATIO     = 4,
    parameter logic [DSIZE-1:0]   PAD_VALUE = '0
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic             in_tlast,
    output logic [DSIZE-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic             out_tlast,
    output logic             pad_active
`ifdef BEAT_ALIGN_KEEP_EN
    ,
    output logic             out_tuser
`endif
);

    localparam int                 c_CNT_W    = clog2_min1(RATIO);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(RATIO - 1);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    align_state_t       state_q,      state_d;
    logic [c_CNT_W-1:0] beat_idx_q,   beat_idx_d;
    logic [c_CNT_W-1:0] pad_left_q,   pad_left_d;
    logic [DSIZE-1:0]   out_tdata_q,  out_tdata_d;
    logic               out_tvalid_q, out_tvalid_d;
    logic               out_tlast_q,  out_tlast_d;
`ifdef BEAT_ALIGN_KEEP_EN
    logic               out_tuser_q,  out_tuser_d;
`endif

    logic               w_load_en;
    logic               w_in_accept;
    logic               w_idx_at_last;
    logic [c_CNT_W-1:0] w_idx_next;
    logic               w_short_last;

    // The output slice can take a new beat when it is empty or draining.
    // This single enable is shared by the FSM and the data path.
    assign w_load_en     = !out_tvalid_q || out_tready;
    assign w_in_accept   = in_tvalid && in_tready;
    assign w_idx_at_last = (beat_idx_q == c_LAST_IDX);
    assign w_idx_next    = w_idx_at_last ? '0 : (beat_idx_q + c_ONE);
    // A tlast that does not land on the final granule slot needs padding.
    // With RATIO==1 the index is always at the last slot, so PAD is unreachable.
    assign w_short_last  = w_in_accept && in_tlast && !w_idx_at_last;

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PASS;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            PASS: begin
                if (w_short_last) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                // Leaving PAD on the final pad load; in_tready only rises on
                // the following cycle, so the next packet never shares it.
                if (w_load_en && (pad_left_q == c_ONE)) begin
                    state_d = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        in_tready  = 1'b0;
        pad_active = 1'b0;
        case (state_q)
            PASS:    in_tready  = w_load_en;
            PAD:     pad_active = 1'b1;
            default: in_tready  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output slice, beat index and pad countdown
    // ------------------------------------------------------------------------
    always_comb begin
        beat_idx_d   = beat_idx_q;
        pad_left_d   = pad_left_q;
        out_tdata_d  = out_tdata_q;
        out_tvalid_d = out_tvalid_q;
        out_tlast_d  = out_tlast_q;
`ifdef BEAT_ALIGN_KEEP_EN
        out_tuser_d  = out_tuser_q;
`endif
        if (w_load_en) begin
            case (state_q)
                PAD: begin
                    out_tdata_d  = PAD_VALUE;
                    out_tvalid_d = 1'b1;
                    out_tlast_d  = (pad_left_q == c_ONE);
                    pad_left_d   = pad_left_q - c_ONE;
                    beat_idx_d   = (pad_left_q == c_ONE) ? '0 : w_idx_next;
`ifdef BEAT_ALIGN_KEEP_EN
                    out_tuser_d  = 1'b1;
`endif
                end
                default: begin
                    if (w_in_accept) begin
                        out_tdata_d  = in_tdata;
                        out_tvalid_d = 1'b1;
                        out_tlast_d  = in_tlast && w_idx_at_last;
                        // Padding continues counting from the slot after the
                        // short last beat; a full-granule last wraps to zero.
                        beat_idx_d   = (in_tlast && w_idx_at_last) ? '0 : w_idx_next;
`ifdef BEAT_ALIGN_KEEP_EN
                        out_tuser_d  = 1'b0;
`endif
                        if (w_short_last) begin
                            pad_left_d = c_LAST_IDX - beat_idx_q;
                        end
                    end else begin
                        // Slice drained with nothing new to load.
                        out_tvalid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx_q   <= '0;
            pad_left_q   <= '0;
            out_tdata_q  <= '0;
            out_tvalid_q <= 1'b0;
            out_tlast_q  <= 1'b0;
`ifdef BEAT_ALIGN_KEEP_EN
            out_tuser_q  <= 1'b0;
`endif
        end else begin
            beat_idx_q   <= beat_idx_d;
            pad_left_q   <= pad_left_d;
            out_tdata_q  <= out_tdata_d;
            out_tvalid_q <= out_tvalid_d;
            out_tlast_q  <= out_tlast_d;
`ifdef BEAT_ALIGN_KEEP_EN
            out_tuser_q  <= out_tuser_d;
`endif
        end
    end

    assign out_tdata  = out_tdata_q;
    assign out_tvalid = out_tvalid_q;
    assign out_tlast  = out_tlast_q;
`ifdef BEAT_ALIGN_KEEP_EN
    assign out_tuser  = out_tuser_q;
`endif

    // ------------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_hold_while_stalled : assert property (
        @(posedge clock) disable iff (!rst_n)
        (out_tvalid_q && !out_tready) |=>
            (out_tvalid_q && $stable(out_tdata_q) && $stable(out_tlast_q))
    );

    a_no_accept_in_pad : assert property (
        @(posedge clock) disable iff (!rst_n)
        (state_q == PAD) |-> !in_tready
    );

    a_pad_left_nonzero : assert property (
        @(posedge clock) disable iff (!rst_n)
        (state_q == PAD) |-> (pad_left_q != '0)
    );
`endif

endmodule : axis_beat_align_pad
`default_nettype wire

// File: tb/tb_axis_beat_align_pad.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_beat_align_pad
// Description : Scoreboard bench for axis_beat_align_pad (DSIZE=8, RATIO=4,
//               PAD_VALUE=8'hEE). A packet-level model pushes the expected
//               output beats when a packet is issued; an independent monitor
//               pops and compares on every output handshake.
//               Define BEAT_ALIGN_KEEP_EN to also check out_tuser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_beat_align_pad;

    localparam int         DSIZE = 8;
    localparam int         RATIO = 4;
    localparam logic [7:0] PADV  = 8'hEE;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic [DSIZE-1:0] in_tdata = '0;
    logic             in_tvalid = 1'b0;
    logic             in_tready;
    logic             in_tlast = 1'b0;
    logic [DSIZE-1:0] out_tdata;
    logic             out_tvalid;
    logic             out_tready = 1'b1;
    logic             out_tlast;
    logic             pad_active;
`ifdef BEAT_ALIGN_KEEP_EN
    logic             out_tuser;
`endif

    axis_beat_align_pad #(
        .DSIZE     (DSIZE),
        .RATIO     (RATIO),
        .PAD_VALUE (PADV)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tlast   (in_tlast),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .pad_active (pad_active)
`ifdef BEAT_ALIGN_KEEP_EN
        ,
        .out_tuser  (out_tuser)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] pkt[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
    int         pad_cycles = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a packet of n beats leaves as the same n beats followed
    // by filler up to the next multiple of RATIO, tlast on the very last beat.
    task automatic expect_pkt();
        int n;
        int tot;
        beat_t b;
        n   = pkt.size();
        tot = ((n + RATIO - 1) / RATIO) * RATIO;
        for (int i = 0; i < tot; i++) begin
            if (i < n) begin
                b.data = pkt[i];
                b.user = 1'b0;
            end else begin
                b.data = PADV;
                b.user = 1'b1;
            end
            b.last = (i == tot - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        bit acc;
        int cyc;
        acc       = 1'b0;
        cyc       = 0;
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tlast  = l;
        while (!acc && cyc < 200) begin
            @(negedge clock);
            acc = in_tready;
            @(posedge clock);
            #1;
            cyc++;
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
        end
    endtask

    task automatic send_pkt(input int gap_max);
        expect_pkt();
        for (int i = 0; i < pkt.size(); i++) begin
            send_beat(pkt[i], i == pkt.size() - 1);
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || out_tvalid) && cyc < 1000) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Downstream ready generator.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       out_tready = 1'b1;
                1:       out_tready = ~out_tready;
                default: out_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares every handshaked output beat against the scoreboard
    // and checks the slice holds while stalled.
    initial begin
        bit    prev_stall;
        beat_t prev;
        beat_t e;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clock);
            if (!rst_n || !mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", out_tvalid, 1);
                    chk("stall_data", out_tdata, prev.data);
                    chk("stall_last", out_tlast, prev.last);
                end
                if (pad_active) begin
                    pad_cycles++;
                    chk("pad_in_tready", in_tready, 0);
                end
                if (out_tvalid && out_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat",
                                 out_tdata, out_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_tdata, e.data);
                        chk("out_last", out_tlast, e.last);
`ifdef BEAT_ALIGN_KEEP_EN
                        chk("out_user", out_tuser, e.user);
`endif
                    end
                end
                prev_stall = out_tvalid && !out_tready;
                prev.data  = out_tdata;
                prev.last  = out_tlast;
            end
        end
    end

    initial begin
        int cnt;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_out_tlast", out_tlast, 0);
        chk("rst_out_tdata", out_tdata, 0);
        chk("rst_pad_active", pad_active, 0);
`ifdef BEAT_ALIGN_KEEP_EN
        chk("rst_out_tuser", out_tuser, 0);
`endif
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clock);
        #1;

        // 1: exact-granule packet, no padding
        pad_cycles = 0;
        pkt = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt(0);
        drain();
        chk("t1_pad_cycles", pad_cycles, 0);

        // 2: single-beat packet, three pad beats, in_tready low for 3 cycles
        pkt = '{8'h0A};
        send_pkt(0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (in_tready) break;
            cnt++;
        end
        chk("t2_in_tready_low_cycles", cnt, 3);
        drain();

        // 3: six beats padded to eight, next packet starts aligned
        pkt = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        send_pkt(0);
        pkt = '{8'h31, 8'h32, 8'h33, 8'h34};
        send_pkt(0);
        drain();

        // 4: same with downstream ready toggling every cycle
        ready_mode = 1;
        pkt = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        send_pkt(0);
        drain();
        ready_mode = 0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end

        // 5: reset during the second pad beat discards the packet
        pkt = '{8'h0A};
        send_pkt(0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("t5_pad2_data", out_tdata, PADV);
        chk("t5_pad2_active", pad_active, 1);
        chk("t5_queue_before_reset", exp_q.size(), 2);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        chk("t5_out_tvalid_after_rst", out_tvalid, 0);
        chk("t5_in_tready_after_rst", in_tready, 1);
        chk("t5_pad_active_after_rst", pad_active, 0);
        @(posedge clock);
        #1;
        pkt = '{8'h21, 8'h22, 8'h23, 8'h24};
        send_pkt(0);
        drain();

        // Randomized packets with random gaps and random downstream ready
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 9);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
            send_pkt(2);
        end
        drain();
        ready_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_axis_beat_align_pad
`default_nettype wire
